// File: rtl/dm_be_init.sv
// dm_be_init -- byte-lane data memory for the MEM stage.
//   Byte/half/word stores through byte enables, sign/zero-extended loads,
//   combinational misalignment and range exceptions, and a one-word-per-cycle
//   clear sweep (INIT) after every reset.
// Optional feature: define DM_TRACE_EN to print every committed store.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   addr            byte address
//   WD              store data, right-aligned
//   WE / RE         store request / load request
//   size            00 byte, 01 half, 10/11 word
//   lsign           1 sign-extend loads, 0 zero-extend
//   PC              PC of the storing instruction (trace only)
//   data            extended load result (0 when not a clean load)
//   busy            init sweep in progress
//   exc_align       misaligned access
//   exc_range       word index beyond the array
module dm_be_init #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W       = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic        RE,
  input  logic [1:0]  size,
  input  logic        lsign,
  input  logic [31:0] PC,
  output logic [31:0] data,
  output logic        busy,
  output logic        exc_align,
  output logic        exc_range
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             r_state, w_state_nx;
  logic [IDX_W-1:0]   r_idx, w_idx_nx;
  logic               w_clr;

  logic [31:0]        r_mem [DEPTH_WORDS];

  logic [29:0]        w_wi;
  logic               w_oor;
  logic               w_mis;
  logic               w_acc;
  logic [IDX_W-1:0]   w_ridx;
  logic [31:0]        w_rword;
  logic [3:0]         w_be;
  logic [31:0]        w_wdat;
  logic [31:0]        w_merged;
  logic               w_commit;
  logic [7:0]         w_lb;
  logic [15:0]        w_lh;
  logic [31:0]        w_ld;

  // ---------------- init FSM ----------------
  always_ff @(posedge clk) begin
    r_state <= w_state_nx;
    r_idx   <= w_idx_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_clr      = 1'b0;
    if (reset) begin
      w_state_nx = S_INIT;
      w_idx_nx   = '0;
    end else begin
      case (r_state)
        S_INIT: begin
          w_clr    = 1'b1;
          w_idx_nx = r_idx + 1'b1;
          if (r_idx == IDX_W'(DEPTH_WORDS - 1)) begin
            w_state_nx = S_RUN;
            w_idx_nx   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_INIT);

  // ---------------- address decode ----------------
  assign w_wi  = addr[31:2];
  assign w_oor = (w_wi >= 30'(DEPTH_WORDS));
  assign w_mis = ((size == 2'b01) & addr[0]) | (size[1] & (addr[1:0] != 2'b00));
  // While sweeping, the memory looks inert: no exceptions, no data.
  assign w_acc = (RE | WE) & ~busy;

  assign exc_range = w_acc & w_oor;
  assign exc_align = w_acc & w_mis;

  // Out-of-range accesses never reach the array; index 0 is a harmless stand-in.
  assign w_ridx  = w_oor ? '0 : w_wi[IDX_W-1:0];
  assign w_rword = r_mem[w_ridx];

  // ---------------- store lane merge ----------------
  always_comb begin
    w_be   = 4'b1111;
    w_wdat = WD;
    case (size)
      2'b00: begin
        w_be   = 4'b0001 << addr[1:0];
        w_wdat = {4{WD[7:0]}};
      end
      2'b01: begin
        w_be   = addr[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{WD[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_merged = w_rword;
    for (int k = 0; k < 4; k++)
      if (w_be[k]) w_merged[8*k +: 8] = w_wdat[8*k +: 8];
  end

  assign w_commit = WE & ~reset & ~busy & ~w_oor & ~w_mis;

  // A single write port serves both the sweep and ordinary stores.
  always_ff @(posedge clk) begin
    if (w_clr)
      r_mem[r_idx] <= '0;
    else if (w_commit)
      r_mem[w_ridx] <= w_merged;
  end

  // ---------------- load extract / extend ----------------
  always_comb begin
    case (addr[1:0])
      2'b00:   w_lb = w_rword[7:0];
      2'b01:   w_lb = w_rword[15:8];
      2'b10:   w_lb = w_rword[23:16];
      default: w_lb = w_rword[31:24];
    endcase
  end

  assign w_lh = addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    case (size)
      2'b00:   w_ld = {{24{lsign & w_lb[7]}}, w_lb};
      2'b01:   w_ld = {{16{lsign & w_lh[15]}}, w_lh};
      default: w_ld = w_rword;
    endcase
  end

  assign data = (RE & ~busy & ~w_oor & ~w_mis) ? w_ld : 32'h0;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (w_commit)
      $display("@%h: *%h <= %h", PC, {addr[31:2], 2'b00}, w_merged);
  end
`else
  logic w_unused_pc;
  assign w_unused_pc = ^PC;
`endif

endmodule

// File: tb/tb_dm_be_init.sv
module tb_dm_be_init;

  localparam int DEPTH = 3072;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, WD, PC;
  logic        WE, RE, lsign;
  logic [1:0]  size;
  logic [31:0] data;
  logic        busy, exc_align, exc_range;

  dm_be_init dut (
    .clk(clk), .reset(reset), .addr(addr), .WD(WD), .WE(WE), .RE(RE),
    .size(size), .lsign(lsign), .PC(PC), .data(data), .busy(busy),
    .exc_align(exc_align), .exc_range(exc_range)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // reference memory: plain array of words
  logic [31:0] ref_mem [DEPTH];
  logic        m_busy;
  logic [31:0] last_data;
  logic        last_al, last_rng;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic m_range(input logic [31:0] a);
    return (a >> 2) >= DEPTH;
  endfunction

  // an access is aligned when its byte offset is a multiple of its size
  function automatic logic m_misal(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz,
                                         input logic sg);
    logic [31:0] w, v, mask;
    int n;
    n = nbytes(sz);
    w = ref_mem[a >> 2];
    if (n == 4) return w;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = (w >> (8 * (a % 4))) & mask;
    if (sg && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] w;
    int p;
    w = ref_mem[a >> 2];
    for (int k = 0; k < nbytes(sz); k++) begin
      p = int'(a % 4) + k;
      w[8*p +: 8] = wd[8*k +: 8];
    end
    ref_mem[a >> 2] = w;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  // one access cycle: check combinational outputs, then commit on the edge
  task automatic op(input logic we, input logic re, input logic [31:0] a,
                    input logic [31:0] wd, input logic [1:0] sz, input logic sg);
    logic rng, al, act;
    logic [31:0] exp_d;
    act   = (we | re) & ~m_busy;
    rng   = act & m_range(a);
    al    = act & m_misal(a, sz);
    exp_d = (re && !m_busy && !m_range(a) && !m_misal(a, sz)) ? m_load(a, sz, sg) : 32'h0;
    WE = we; RE = re; addr = a; WD = wd; size = sz; lsign = sg;
    #1;
    chk("data", data, exp_d);
    chk("exc_align", 32'(exc_align), 32'(al));
    chk("exc_range", 32'(exc_range), 32'(rng));
    last_data = data; last_al = exc_align; last_rng = exc_range;
    @(posedge clk); #1;
    if (we && !m_busy && !m_range(a) && !m_misal(a, sz)) m_store(a, wd, sz);
    WE = 1'b0; RE = 1'b0;
  endtask

  task automatic rst_pulse();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_busy = 1'b1;
    chk("busy_after_reset", 32'(busy), 32'd1);
  endtask

  task automatic sweep_wait();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sweep_len", n, DEPTH);
    m_busy = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [31:0] a;
    int pick;
    reset = 1'b1; addr = 0; WD = 0; PC = 32'h3000; WE = 0; RE = 0; size = 0; lsign = 0;
    m_busy = 1'b1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    RE = 1'b1;
    #1;
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_data", data, 32'h0);
    RE = 1'b0;
    reset = 1'b0;
    sweep_wait();

    // byte lanes
    op(1, 0, 32'h10, 32'h11223344, 2'b10, 0);
    op(1, 0, 32'h12, 32'h000000AA, 2'b00, 0);
    op(0, 1, 32'h10, 0, 2'b10, 0);  chk("lw_lanes", last_data, 32'h11AA3344);
    op(0, 1, 32'h12, 0, 2'b00, 1);  chk("lb",       last_data, 32'hFFFFFFAA);
    op(0, 1, 32'h12, 0, 2'b00, 0);  chk("lbu",      last_data, 32'h000000AA);

    // halfword
    op(1, 0, 32'h22, 32'h00008001, 2'b01, 0);
    op(0, 1, 32'h20, 0, 2'b10, 0);  chk("lw_half",  last_data, 32'h80010000);
    op(0, 1, 32'h22, 0, 2'b01, 1);  chk("lh",       last_data, 32'hFFFF8001);
    op(0, 1, 32'h22, 0, 2'b01, 0);  chk("lhu",      last_data, 32'h00008001);

    // exceptions
    op(1, 0, 32'h13, 32'hCAFEF00D, 2'b10, 0);  chk("sw_mis_align", 32'(last_al), 32'd1);
    op(0, 1, 32'h10, 0, 2'b10, 0);  chk("sw_mis_unchanged", last_data, 32'h11AA3344);
    op(0, 1, 32'h3000, 0, 2'b10, 0);
    chk("lw_oor_range", 32'(last_rng), 32'd1);
    chk("lw_oor_data",  last_data, 32'h0);
    op(1, 0, 32'h1, 32'h1234, 2'b01, 0);  chk("sh_mis_align", 32'(last_al), 32'd1);
    op(0, 1, 32'h2FFC, 0, 2'b10, 0);  chk("last_word_range", 32'(last_rng), 32'd0);

    // init sweep clears a preloaded word
    op(1, 0, 32'h14, 32'hDEADBEEF, 2'b10, 0);
    op(0, 1, 32'h14, 0, 2'b10, 0);  chk("preload", last_data, 32'hDEADBEEF);
    rst_pulse();
    sweep_wait();
    op(0, 1, 32'h14, 0, 2'b10, 0);  chk("cleared", last_data, 32'h0);

    // reset mid-sweep, store dropped while busy
    rst_pulse();
    repeat (999) @(posedge clk);
    #1;
    op(1, 1, 32'h40, 32'h5A5A5A5A, 2'b10, 0);
    rst_pulse();
    sweep_wait();
    op(0, 1, 32'h40, 0, 2'b10, 0);  chk("busy_store_dropped", last_data, 32'h0);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 9);
      if (pick < 8)       a = 32'($urandom_range(0, 63));
      else if (pick == 8) a = 32'h2FF0 + 32'($urandom_range(0, 15));
      else                a = 32'h3000 + 32'($urandom_range(0, 4095));
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
         2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
